arp_rx: RTL and testbench

ARP receive parser for the UDP/ARP stack: it sits on the GMII receive path beside the ARP transmitter and the frame CRC logic. It watches raw GMII bytes, validates preamble/SFD, Ethernet header and ARP payload, and when an ARP request or reply targeted at this board arrives it pulses `arp_rx_done` with the sender's MAC/IP and the ARP opcode type. The ARP control logic uses this to answer requests (`arp_tx_type`=1) and to learn the peer address (`des_mac`/`des_ip`). No FCS check is done here: frames are accepted on content alone.

---
 rtl/arp_rx.sv | 154 +++++++++++++++
 tb/tb_arp_rx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/arp_rx.sv
// ARP receive parser: checks preamble/SFD, Ethernet header and ARP payload on the
// GMII receive path and reports the sender of ARP requests/replies aimed at this board.
module arp_rx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  localparam int unsigned CNT_W = 5;

  typedef enum logic [4:0] {
    st_idle     = 5'b00001,
    st_preamble = 5'b00010,
    st_eth_head = 5'b00100,
    st_arp_data = 5'b01000,
    st_rx_end   = 5'b10000
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [39:0]        r_dmac;
  logic [7:0]         r_etype_hi;
  logic [15:0]        r_op;
  logic [47:0]        r_smac;
  logic [31:0]        r_sip;
  logic [23:0]        r_tip;
  logic               r_accept;
  logic               r_op_reply;

  logic [47:0]        w_dmac_full;
  logic [31:0]        w_tip_full;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_dmac_full = {r_dmac, gmii_rxd};
  assign w_tip_full  = {r_tip, gmii_rxd};
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

  // Parser FSM; the accept decision is registered and published one edge after byte 27.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= st_idle;
      r_cnt       <= '0;
      r_dmac      <= '0;
      r_etype_hi  <= '0;
      r_op        <= '0;
      r_smac      <= '0;
      r_sip       <= '0;
      r_tip       <= '0;
      r_accept    <= 1'b0;
      r_op_reply  <= 1'b0;
      arp_rx_done <= 1'b0;
      arp_rx_type <= 1'b0;
      src_mac     <= '0;
      src_ip      <= '0;
    end else begin
      arp_rx_done <= 1'b0;
      if (r_accept) begin
        r_accept    <= 1'b0;
        arp_rx_done <= 1'b1;
        arp_rx_type <= r_op_reply;
        src_mac     <= r_smac;
        src_ip      <= r_sip;
      end

      unique case (r_state)
        st_idle: begin
          if (gmii_rx_dv) begin
            if (gmii_rxd == 8'h55) begin
              r_state <= st_preamble;
              r_cnt   <= CNT_W'(1);
            end else begin
              r_state <= st_rx_end;
              r_cnt   <= '0;
            end
          end
        end

        st_preamble: begin
          if (!gmii_rx_dv) begin
            r_state <= st_idle;
            r_cnt   <= '0;
          end else if (gmii_rxd == 8'h55 && r_cnt < CNT_W'(7)) begin
            r_cnt <= w_cnt_inc;
          end else if (gmii_rxd == 8'hd5 && r_cnt == CNT_W'(7)) begin
            r_state <= st_eth_head;
            r_cnt   <= '0;
          end else begin
            r_state <= st_rx_end;
            r_cnt   <= '0;
          end
        end

        st_eth_head: begin
          if (!gmii_rx_dv) begin
            r_state <= st_idle;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (r_cnt < CNT_W'(5)) r_dmac <= {r_dmac[31:0], gmii_rxd};
            if (r_cnt == CNT_W'(12)) r_etype_hi <= gmii_rxd;
            if (r_cnt == CNT_W'(5) && w_dmac_full != BOARD_MAC &&
                w_dmac_full != 48'hff_ff_ff_ff_ff_ff) begin
              r_state <= st_rx_end;
              r_cnt   <= '0;
            end
            if (r_cnt == CNT_W'(13)) begin
              r_state <= ({r_etype_hi, gmii_rxd} == 16'h0806) ? st_arp_data : st_rx_end;
              r_cnt   <= '0;
            end
          end
        end

        st_arp_data: begin
          if (!gmii_rx_dv) begin
            r_state <= st_idle;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (r_cnt == CNT_W'(6)) r_op[15:8] <= gmii_rxd;
            if (r_cnt == CNT_W'(7)) r_op[7:0]  <= gmii_rxd;
            if (r_cnt >= CNT_W'(8) && r_cnt <= CNT_W'(13)) r_smac <= {r_smac[39:0], gmii_rxd};
            if (r_cnt >= CNT_W'(14) && r_cnt <= CNT_W'(17)) r_sip <= {r_sip[23:0], gmii_rxd};
            if (r_cnt >= CNT_W'(24) && r_cnt <= CNT_W'(26)) r_tip <= {r_tip[15:0], gmii_rxd};
            if (r_cnt == CNT_W'(27)) begin
              r_state    <= st_rx_end;
              r_cnt      <= '0;
              r_op_reply <= (r_op == 16'h0002);
              r_accept   <= (w_tip_full == BOARD_IP) &&
                            (r_op == 16'h0001 || r_op == 16'h0002);
            end
          end
        end

        st_rx_end: begin
          if (!gmii_rx_dv) r_state <= st_idle;
        end

        default: begin
          r_state <= st_idle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arp_rx.sv
// Directed-vector bench for arp_rx: builds GMII frames byte by byte and checks
// done pulses, pulse timing and held output values against hand-derived expectations.
module tb_arp_rx;

  localparam logic [47:0] BM  = 48'h00_11_22_33_44_55;
  localparam logic [31:0] BIP = 32'hc0a8010a;
  localparam logic [47:0] BC  = 48'hff_ff_ff_ff_ff_ff;

  logic        clk;
  logic        rst_n;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic        arp_rx_done;
  logic        arp_rx_type;
  logic [47:0] src_mac;
  logic [31:0] src_ip;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int n_done  = 0;
  int n_dbl   = 0;
  int last_done_cyc = -1;
  logic prev_done = 1'b0;

  logic        exp_type = 1'b0;
  logic [47:0] exp_mac  = '0;
  logic [31:0] exp_ip   = '0;

  arp_rx #(.BOARD_MAC(BM), .BOARD_IP(BIP)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rxd    (gmii_rxd),
    .arp_rx_done (arp_rx_done),
    .arp_rx_type (arp_rx_type),
    .src_mac     (src_mac),
    .src_ip      (src_ip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Done-pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (arp_rx_done) begin
      n_done++;
      last_done_cyc = cyc;
      if (prev_done) n_dbl++;
    end
    prev_done = arp_rx_done;
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_bytes(inout logic [7:0] q[$], input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) q.push_back(v[i*8 +: 8]);
  endtask

  // abort_at: ARP bytes sent before dv drops (-1 = whole frame); rst_at: byte index of a reset pulse.
  task automatic send_frame(input string tag, input logic [47:0] dmac, input logic [15:0] etype,
                            input logic [15:0] op, input logic [47:0] smac, input logic [31:0] sip,
                            input logic [31:0] tip, input int npre, input int abort_at,
                            input int rst_at, input int gap, input bit acc);
    logic [7:0] q[$];
    int done0;
    int b27;
    int idx27;
    done0 = n_done;
    b27   = -100;
    for (int i = 0; i < npre; i++) q.push_back(8'h55);
    q.push_back(8'hd5);
    push_bytes(q, 64'(dmac), 6);
    push_bytes(q, 64'(smac), 6);
    push_bytes(q, 64'(etype), 2);
    push_bytes(q, 64'h0001_0800_0604, 6);
    push_bytes(q, 64'(op), 2);
    push_bytes(q, 64'(smac), 6);
    push_bytes(q, 64'(sip), 4);
    push_bytes(q, 64'h0, 6);
    push_bytes(q, 64'(tip), 4);
    for (int i = 0; i < 18; i++) q.push_back(8'h00);
    for (int i = 0; i < 4; i++) q.push_back(8'ha5);
    idx27 = npre + 1 + 14 + 27;
    if (abort_at >= 0)
      while (q.size() > npre + 15 + abort_at) void'(q.pop_back());

    for (int i = 0; i < q.size(); i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        #2;
        chk_eq({tag, "/rst_done"}, 64'(arp_rx_done), 64'd0);
        chk_eq({tag, "/rst_type"}, 64'(arp_rx_type), 64'd0);
        chk_eq({tag, "/rst_mac"},  64'(src_mac), 64'd0);
        chk_eq({tag, "/rst_ip"},   64'(src_ip), 64'd0);
        exp_type = 1'b0;
        exp_mac  = '0;
        exp_ip   = '0;
        rst_n = 1'b1;
      end
      gmii_rxd   = q[i];
      gmii_rx_dv = 1'b1;
      @(posedge clk); #1;
      if (i == idx27) b27 = cyc;
    end
    for (int i = 0; i < gap; i++) begin
      gmii_rx_dv = 1'b0;
      gmii_rxd   = 8'h00;
      @(posedge clk); #1;
    end
    @(negedge clk); #1;

    chk_eq({tag, "/done_cnt"}, 64'(n_done - done0), acc ? 64'd1 : 64'd0);
    if (acc) begin
      chk_eq({tag, "/done_lat"}, 64'(last_done_cyc), 64'(b27 + 1));
      exp_type = (op == 16'h0002);
      exp_mac  = smac;
      exp_ip   = sip;
    end
    chk_eq({tag, "/type"}, 64'(arp_rx_type), 64'(exp_type));
    chk_eq({tag, "/mac"},  64'(src_mac), 64'(exp_mac));
    chk_eq({tag, "/ip"},   64'(src_ip), 64'(exp_ip));
  endtask

  initial begin
    rst_n      = 1'b0;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset/done", 64'(arp_rx_done), 64'd0);
    chk_eq("reset/type", 64'(arp_rx_type), 64'd0);
    chk_eq("reset/mac",  64'(src_mac), 64'd0);
    chk_eq("reset/ip",   64'(src_ip), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send_frame("bcast_req", BC, 16'h0806, 16'h0001, 48'h000a3501fec0, 32'hc0a80166, BIP, 7, -1, -1, 4, 1'b1);
    chk_eq("bcast_req/exact_mac", 64'(src_mac), 64'h000a3501fec0);
    chk_eq("bcast_req/exact_ip",  64'(src_ip),  64'hc0a80166);
    send_frame("ucast_rep", BM, 16'h0806, 16'h0002, 48'h000a3501fec1, 32'hc0a80167, BIP, 7, -1, -1, 4, 1'b1);
    chk_eq("ucast_rep/exact_type", 64'(arp_rx_type), 64'd1);

    send_frame("rej_tip",   BM, 16'h0806, 16'h0001, 48'h0a0b0c0d0e01, 32'hc0a80170, 32'hc0a8010b, 7, -1, -1, 3, 1'b0);
    send_frame("rej_dmac",  48'h001122334456, 16'h0806, 16'h0001, 48'h0a0b0c0d0e02, 32'hc0a80171, BIP, 7, -1, -1, 3, 1'b0);
    send_frame("rej_etype", BM, 16'h0800, 16'h0001, 48'h0a0b0c0d0e03, 32'hc0a80172, BIP, 7, -1, -1, 3, 1'b0);
    send_frame("rej_op3",   BM, 16'h0806, 16'h0003, 48'h0a0b0c0d0e04, 32'hc0a80173, BIP, 7, -1, -1, 3, 1'b0);

    send_frame("pre_short", BM, 16'h0806, 16'h0001, 48'h0a0b0c0d0e05, 32'hc0a80174, BIP, 5, -1, -1, 12, 1'b0);
    send_frame("after_pre", BM, 16'h0806, 16'h0001, 48'h0a0b0c0d0e06, 32'hc0a80175, BIP, 7, -1, -1, 2, 1'b1);
    send_frame("pre_long",  BM, 16'h0806, 16'h0001, 48'h0a0b0c0d0e07, 32'hc0a80176, BIP, 8, -1, -1, 2, 1'b0);

    send_frame("dv_abort",    BC, 16'h0806, 16'h0002, 48'h0a0b0c0d0e08, 32'hc0a80177, BIP, 7, 20, -1, 1, 1'b0);
    send_frame("after_abort", BC, 16'h0806, 16'h0002, 48'h0a0b0c0d0e09, 32'hc0a80178, BIP, 7, -1, -1, 2, 1'b1);

    send_frame("rst_mid",   BM, 16'h0806, 16'h0001, 48'h0a0b0c0d0e0a, 32'hc0a80179, BIP, 7, -1, 13, 2, 1'b0);
    send_frame("after_rst", BM, 16'h0806, 16'h0001, 48'h0a0b0c0d0e0b, 32'hc0a8017a, BIP, 7, -1, -1, 2, 1'b1);

    send_frame("nogap_a", BM, 16'h0806, 16'h0002, 48'h0a0b0c0d0e0c, 32'hc0a8017b, BIP, 7, -1, -1, 0, 1'b1);
    send_frame("nogap_b", BM, 16'h0806, 16'h0001, 48'h0a0b0c0d0e0d, 32'hc0a8017c, BIP, 7, -1, -1, 2, 1'b0);

    send_frame("dv_drop_at_accept", BC, 16'h0806, 16'h0001, 48'h0a0b0c0d0e0e, 32'hc0a8017d, BIP, 7, 28, -1, 1, 1'b1);
    send_frame("after_drop", BM, 16'h0806, 16'h0002, 48'h0a0b0c0d0e0f, 32'hc0a8017e, BIP, 7, -1, -1, 2, 1'b1);

    chk_eq("no_double_done", 64'(n_dbl), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
